// File: rtl/amstrad_audio_mixer_if.sv
// Board-side bundle for the stereo mixer: sample strobe, channel samples, config port and mix results.
// master = board/PSG side driving samples and config; slave = the mixer.
interface amstrad_audio_mixer_if #(
    parameter int CHANNELS = 3,
    parameter int IN_W     = 8,
    parameter int OUT_W    = 8
);
    logic                     ce;
    logic [CHANNELS*IN_W-1:0] ch_in;
    logic                     mono;
    logic                     cfg_we;
    logic [3:0]               cfg_sel;
    logic [3:0]               cfg_data;
    logic [OUT_W-1:0]         audio_l;
    logic [OUT_W-1:0]         audio_r;
    logic                     valid;
    logic                     busy;
    logic                     overrun;

    modport master (
        output ce, ch_in, mono, cfg_we, cfg_sel, cfg_data,
        input  audio_l, audio_r, valid, busy, overrun
    );

    modport slave (
        input  ce, ch_in, mono, cfg_we, cfg_sel, cfg_data,
        output audio_l, audio_r, valid, busy, overrun
    );
endinterface

// File: rtl/amstrad_audio_mixer.sv
// Time-multiplexed N-channel stereo mixer with per-channel pan/attenuation, mono and saturation.
// ce in cycle 0 -> valid/outputs in cycle CHANNELS+1; ce while not idle is dropped and sets sticky overrun.
module amstrad_audio_mixer #(
    parameter int CHANNELS = 3,
    parameter int IN_W     = 8,
    parameter int OUT_W    = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    amstrad_audio_mixer_if.slave  bus
);
    localparam int IDX_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int ACC_W = IN_W + $clog2(CHANNELS) + 1;

    typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_DONE} state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [ACC_W-1:0]   accl_q, accl_d, accr_q, accr_d;
    logic [OUT_W-1:0]   audl_q, audl_d, audr_q, audr_d;
    logic               overrun_q;
    logic [3:0]         cfg_q   [CHANNELS];
    logic [3:0]         shcfg_q [CHANNELS];
    logic [IN_W-1:0]    samp_q  [CHANNELS];
    logic               mono_q;
    logic               snap;

    logic [1:0]         pan_c;
    logic [1:0]         att_c;
    logic [2:0]         sh_c;
    logic [ACC_W-1:0]   contrib_c;

    // Power-on pan reproduces the classic CPC layout: A left, B centre, C right.
    function automatic logic [3:0] cfg_default(input int ch);
        if (ch == 0)      return 4'b0100;
        else if (ch == 2) return 4'b1000;
        else              return 4'b1100;
    endfunction

    // Saturate to IN_W bits, then align the MSBs of s to the OUT_W output.
    function automatic logic [OUT_W-1:0] sat_scale(input logic [ACC_W-1:0] acc);
        logic [IN_W-1:0]       s;
        logic [OUT_W+IN_W-1:0] w;
        s = (|acc[ACC_W-1:IN_W]) ? {IN_W{1'b1}} : acc[IN_W-1:0];
        w = {s, {OUT_W{1'b0}}};
        return w[OUT_W+IN_W-1 -: OUT_W];
    endfunction

    always_comb begin
        pan_c = shcfg_q[idx_q][3:2];
        att_c = shcfg_q[idx_q][1:0];
        if (mono_q && pan_c != 2'b00) begin
            pan_c = 2'b11;
        end
        sh_c      = ((pan_c == 2'b11) ? 3'd2 : 3'd1) + {1'b0, att_c};
        contrib_c = ACC_W'(samp_q[idx_q] >> sh_c);
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        accl_d  = accl_q;
        accr_d  = accr_q;
        audl_d  = audl_q;
        audr_d  = audr_q;
        snap    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.ce) begin
                    snap    = 1'b1;
                    accl_d  = '0;
                    accr_d  = '0;
                    idx_d   = '0;
                    state_d = S_ACCUM;
                end
            end
            S_ACCUM: begin
                // pan bit 0 feeds left, bit 1 feeds right; 11 feeds both
                if (pan_c[0]) accl_d = accl_q + contrib_c;
                if (pan_c[1]) accr_d = accr_q + contrib_c;
                if (idx_q == IDX_W'(CHANNELS - 1)) begin
                    audl_d  = sat_scale(accl_d);
                    audr_d  = sat_scale(accr_d);
                    state_d = S_DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            idx_q     <= '0;
            accl_q    <= '0;
            accr_q    <= '0;
            audl_q    <= '0;
            audr_q    <= '0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            accl_q    <= accl_d;
            accr_q    <= accr_d;
            audl_q    <= audl_d;
            audr_q    <= audr_d;
            overrun_q <= overrun_q | (bus.ce && state_q != S_IDLE);
        end
    end

    // Live config is written freely; the shadow copy taken at ce is what the sample in flight uses.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mono_q <= 1'b0;
            for (int i = 0; i < CHANNELS; i++) begin
                cfg_q[i]   <= cfg_default(i);
                shcfg_q[i] <= '0;
                samp_q[i]  <= '0;
            end
        end else begin
            if (snap) begin
                mono_q <= bus.mono;
            end
            for (int i = 0; i < CHANNELS; i++) begin
                if (snap) begin
                    shcfg_q[i] <= cfg_q[i];
                    samp_q[i]  <= bus.ch_in[i*IN_W +: IN_W];
                end
                if (bus.cfg_we && bus.cfg_sel == 4'(i)) begin
                    cfg_q[i] <= bus.cfg_data;
                end
            end
        end
    end

    assign bus.audio_l = audl_q;
    assign bus.audio_r = audr_q;
    assign bus.valid   = (state_q == S_DONE);
    assign bus.busy    = (state_q == S_ACCUM);
    assign bus.overrun = overrun_q;
endmodule

// File: tb/tb_amstrad_audio_mixer.sv
// Randomised self-checking bench for amstrad_audio_mixer against an arithmetic pan/attenuation model.
module tb_amstrad_audio_mixer;
    localparam int CH = 3;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    amstrad_audio_mixer_if #(.CHANNELS(CH), .IN_W(8), .OUT_W(8)) bus ();
    amstrad_audio_mixer_if #(.CHANNELS(8),  .IN_W(8), .OUT_W(8)) bus8 ();

    amstrad_audio_mixer #(.CHANNELS(CH), .IN_W(8), .OUT_W(8)) u_dut (
        .clk(clk), .reset_n(reset_n), .bus(bus)
    );
    amstrad_audio_mixer #(.CHANNELS(8), .IN_W(8), .OUT_W(8)) u_dut8 (
        .clk(clk), .reset_n(reset_n), .bus(bus8)
    );

    int errs = 0;
    int checks = 0;
    int pan_m [16];
    int att_m [16];
    int samp_m [16];
    bit ovr_m = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic reset_model();
        for (int i = 0; i < 16; i++) begin
            pan_m[i] = (i == 0) ? 1 : (i == 2) ? 2 : 3;
            att_m[i] = 0;
        end
        ovr_m = 1'b0;
    endtask

    // Each channel contributes x / 2^(pan weight + att) to the sides its pan selects.
    task automatic model_mix(input bit mono, output int l, output int r);
        int p, v;
        l = 0;
        r = 0;
        for (int i = 0; i < CH; i++) begin
            p = pan_m[i];
            if (mono && p != 0) p = 3;
            if (p != 0) begin
                v = samp_m[i] / (((p == 3) ? 4 : 2) << att_m[i]);
                if (p == 1 || p == 3) l += v;
                if (p == 2 || p == 3) r += v;
            end
        end
        if (l > 255) l = 255;
        if (r > 255) r = 255;
    endtask

    // kind: 0 plain, 1 cfg write at cycle 2, 2 extra ce at cycle 2, 3 cfg write together with ce
    task automatic run_sample(input bit mono, input int kind, input int wsel, input int wdata);
        int el, er, n, nv;
        bit got;
        model_mix(mono, el, er);
        @(negedge clk);
        for (int i = 0; i < CH; i++) bus.ch_in[i*8 +: 8] = 8'(samp_m[i]);
        bus.mono = mono;
        bus.ce   = 1'b1;
        if (kind == 3) begin
            bus.cfg_we = 1'b1; bus.cfg_sel = 4'(wsel); bus.cfg_data = 4'(wdata);
        end
        @(negedge clk);
        bus.ce = 1'b0;
        bus.cfg_we = 1'b0;
        n = 1;
        got = 1'b0;
        chk("busy_first", bus.busy, 1);
        while (n <= 20 && !got) begin
            if (bus.valid) begin
                got = 1'b1;
            end else begin
                if (n == 2) begin
                    bus.mono  = ~mono;
                    bus.ch_in = {$urandom, $urandom};
                    if (kind == 1) begin
                        bus.cfg_we = 1'b1; bus.cfg_sel = 4'(wsel); bus.cfg_data = 4'(wdata);
                    end
                    if (kind == 2) bus.ce = 1'b1;
                end
                @(negedge clk);
                bus.ce = 1'b0;
                bus.cfg_we = 1'b0;
                n++;
            end
        end
        chk("latency", got ? n : 0, CH + 1);
        chk("audio_l", bus.audio_l, el);
        chk("audio_r", bus.audio_r, er);
        chk("busy_at_valid", bus.busy, 0);
        if ((kind == 1 || kind == 3) && wsel < CH) begin
            pan_m[wsel] = (wdata >> 2) & 3;
            att_m[wsel] = wdata & 3;
        end
        if (kind == 2) ovr_m = 1'b1;
        nv = 0;
        repeat (CH + 2) begin
            @(negedge clk);
            if (bus.valid) nv++;
        end
        chk("single_valid", nv, 0);
        chk("overrun", bus.overrun, ovr_m);
        chk("hold_l", bus.audio_l, el);
    endtask

    task automatic write_cfg(input int sel, input int data);
        @(negedge clk);
        bus.cfg_we = 1'b1; bus.cfg_sel = 4'(sel); bus.cfg_data = 4'(data);
        @(negedge clk);
        bus.cfg_we = 1'b0;
        if (sel < CH) begin
            pan_m[sel] = (data >> 2) & 3;
            att_m[sel] = data & 3;
        end
    endtask

    task automatic set_samples(input int a, input int b, input int c);
        samp_m[0] = a; samp_m[1] = b; samp_m[2] = c;
    endtask

    task automatic run8(input int att, input int exp_l, input int exp_r);
        int n;
        bit got;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            bus8.cfg_we = 1'b1; bus8.cfg_sel = 4'(i); bus8.cfg_data = 4'(4 + att);
        end
        @(negedge clk);
        bus8.cfg_we = 1'b0;
        bus8.ch_in = '1;
        bus8.ce = 1'b1;
        @(negedge clk);
        bus8.ce = 1'b0;
        n = 1;
        got = 1'b0;
        while (n <= 20 && !got) begin
            if (bus8.valid) got = 1'b1;
            else begin
                @(negedge clk);
                n++;
            end
        end
        chk("ch8_latency", got ? n : 0, 9);
        chk("ch8_audio_l", bus8.audio_l, exp_l);
        chk("ch8_audio_r", bus8.audio_r, exp_r);
    endtask

    initial begin
        int el, er, nv, kind;
        bus.ce = 0; bus.ch_in = '0; bus.mono = 0; bus.cfg_we = 0; bus.cfg_sel = 0; bus.cfg_data = 0;
        bus8.ce = 0; bus8.ch_in = '0; bus8.mono = 0; bus8.cfg_we = 0; bus8.cfg_sel = 0; bus8.cfg_data = 0;
        reset_model();
        repeat (3) @(negedge clk);
        chk("rst_audio_l", bus.audio_l, 0);
        chk("rst_audio_r", bus.audio_r, 0);
        chk("rst_valid", bus.valid, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_overrun", bus.overrun, 0);
        reset_n = 1'b1;
        nv = 0;
        repeat (6) begin
            @(negedge clk);
            if (bus.valid || bus.busy) nv++;
        end
        chk("idle_quiet", nv, 0);

        set_samples(8'hFE, 8'hFC, 8'h00);
        run_sample(1'b0, 0, 0, 0);
        chk("cpc_l", bus.audio_l, 8'hBE);
        chk("cpc_r", bus.audio_r, 8'h3F);
        run_sample(1'b1, 0, 0, 0);
        chk("mono_l", bus.audio_l, 8'h7E);
        chk("mono_r", bus.audio_r, 8'h7E);

        set_samples(8'hFE, 8'hFC, 8'h80);
        run_sample(1'b0, 1, 2, 4'b0000);
        chk("midcfg_r_old", bus.audio_r, 8'h7F);
        run_sample(1'b0, 0, 0, 0);
        chk("midcfg_r_new", bus.audio_r, 8'h3F);
        run_sample(1'b0, 3, 2, 4'b1000);
        chk("samecyc_r_old", bus.audio_r, 8'h3F);
        run_sample(1'b0, 0, 0, 0);
        chk("samecyc_r_new", bus.audio_r, 8'h7F);

        for (int it = 0; it < 24; it++) begin
            for (int i = 0; i < CH; i++) samp_m[i] = $urandom_range(0, 255);
            if ($urandom_range(0, 1) == 1) write_cfg($urandom_range(0, 4), $urandom_range(0, 15));
            kind = $urandom_range(0, 2);
            if (kind == 2) kind = 3;
            run_sample($urandom_range(0, 3) == 0, kind, $urandom_range(0, 4), $urandom_range(0, 15));
        end

        for (int i = 0; i < CH; i++) samp_m[i] = $urandom_range(0, 255);
        run_sample(1'b0, 2, 0, 0);

        @(negedge clk);
        bus.ce = 1'b1;
        @(negedge clk);
        bus.ce = 1'b0;
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk("midrst_audio_l", bus.audio_l, 0);
        chk("midrst_audio_r", bus.audio_r, 0);
        chk("midrst_busy", bus.busy, 0);
        chk("midrst_valid", bus.valid, 0);
        chk("midrst_overrun", bus.overrun, 0);
        reset_model();
        @(negedge clk);
        reset_n = 1'b1;
        set_samples(8'hFE, 8'hFC, 8'h80);
        run_sample(1'b0, 0, 0, 0);
        model_mix(1'b0, el, er);
        chk("postrst_r", bus.audio_r, 8'h7F);

        run8(0, 8'hFF, 8'h00);
        run8(3, 8'h78, 8'h00);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
